// File: rtl/nn_sequencer.sv
// -----------------------------------------------------------------------------
// nn_sequencer
//
// This is the handshake controller for the iris classifier datapath (nn).
//
// Operation:
//   - It accepts one 4-feature sample over a valid/ready input channel.
//   - It holds the features stable on the nn_* outputs.
//   - It waits LATENCY cycles for the datapath to settle.
//   - It captures the species code and winning score.
//   - It presents that pair over a valid/ready result channel.
//   - It keeps three saturating per-class result counters for display.
//
// Parameters:
//   LATENCY  cycles from feature launch to a settled nn output (1..255)
//   CNT_W    width of each class counter
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        sample handshake (in_ready is combinational)
//   in_sl, in_sw, in_pl, in_pw sample features
//   nn_sl, nn_sw, nn_pl, nn_pw registered features driven to the datapath
//   nn_species, nn_final       datapath class code and winning score
//   out_valid / out_ready      result handshake
//   out_species, out_score     captured result
//   cnt_c0, cnt_c1, cnt_c2     results delivered per class (saturating)
//   clr_counts                 synchronous clear of all class counters
//   busy                       high whenever the controller is not idle
// -----------------------------------------------------------------------------
module nn_sequencer #(
  parameter int unsigned LATENCY = 24,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sl,
  input  logic [3:0]       in_sw,
  input  logic [3:0]       in_pl,
  input  logic [3:0]       in_pw,

  output logic [3:0]       nn_sl,
  output logic [3:0]       nn_sw,
  output logic [3:0]       nn_pl,
  output logic [3:0]       nn_pw,
  input  logic [3:0]       nn_species,
  input  logic [31:0]      nn_final,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_species,
  output logic [31:0]      out_score,

  output logic [CNT_W-1:0] cnt_c0,
  output logic [CNT_W-1:0] cnt_c1,
  output logic [CNT_W-1:0] cnt_c2,
  input  logic             clr_counts,
  output logic             busy
);

  if (LATENCY == 0 || LATENCY > 255) begin : g_bad_latency
    $error("nn_sequencer: LATENCY must be in 1..255");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("nn_sequencer: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Loading LATENCY-1 and capturing on the cycle the counter reads zero
  // places the capture exactly LATENCY edges after the accept edge.
  localparam logic [7:0]       WAIT_LOAD = 8'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [15:0]      feat_q, feat_d;
  logic [3:0]       species_q, species_d;
  logic [31:0]      score_q, score_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic accept;
  logic capture;

  // The controller can take a new sample when idle.
  // It can also take one in RESULT on the same edge that the current result
  // is consumed, which allows back-to-back operation.
  assign in_ready = (state_q == IDLE) || ((state_q == RESULT) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETTLE;
          wait_d  = WAIT_LOAD;
        end
      end
      SETTLE: begin
        if (wait_q == '0) begin
          capture = 1'b1;
          state_d = RESULT;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          if (accept) begin
            state_d = SETTLE;
            wait_d  = WAIT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The features change only on accept. They stay stable in every other state.
  always_comb begin
    feat_d = feat_q;
    if (accept) begin
      feat_d = {in_sl, in_sw, in_pl, in_pw};
    end
  end

  always_comb begin
    species_d = species_q;
    score_d   = score_q;
    if (capture) begin
      species_d = nn_species;
      score_d   = nn_final;
    end
  end

  // A clear takes priority over a coincident increment.
  // Species codes 3..15 match no counter and are therefore not counted.
  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr_counts) begin
        cnt_d[c] = '0;
      end else if (capture && (nn_species == 4'(c)) && (cnt_q[c] != CNT_MAX)) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      feat_q    <= '0;
      species_q <= '0;
      score_q   <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      feat_q    <= feat_d;
      species_q <= species_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
    end
  end

  assign nn_sl       = feat_q[15:12];
  assign nn_sw       = feat_q[11:8];
  assign nn_pl       = feat_q[7:4];
  assign nn_pw       = feat_q[3:0];
  assign out_valid   = (state_q == RESULT);
  assign out_species = species_q;
  assign out_score   = score_q;
  assign cnt_c0      = cnt_q[0];
  assign cnt_c1      = cnt_q[1];
  assign cnt_c2      = cnt_q[2];
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_nn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_sequencer
//
// This is the testbench for nn_sequencer.
//
// Instances:
//   u_dut   LATENCY=24, CNT_W=4
//   u_dut_b LATENCY=1,  CNT_W=16 (streaming throughput)
//
// For u_dut, the driver pushes the expected result of every accepted sample
// into a queue. The expected result includes the counter values, which come
// from a per-class tally. A separate monitor pops that queue whenever the DUT
// presents a new result, and checks the capture time and the held values.
// -----------------------------------------------------------------------------
module tb_nn_sequencer;

  localparam int unsigned LAT  = 24;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---- main DUT ----
  logic          in_valid   = 1'b0;
  logic          in_ready;
  logic [3:0]    in_sl = '0, in_sw = '0, in_pl = '0, in_pw = '0;
  logic [3:0]    nn_sl, nn_sw, nn_pl, nn_pw;
  logic [3:0]    nn_species = '0;
  logic [31:0]   nn_final   = '0;
  logic          out_valid;
  logic          out_ready  = 1'b0;
  logic [3:0]    out_species;
  logic [31:0]   out_score;
  logic [CW-1:0] cnt_c0, cnt_c1, cnt_c2;
  logic          clr_counts = 1'b0;
  logic          busy;

  nn_sequencer #(.LATENCY(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sl(in_sl), .in_sw(in_sw), .in_pl(in_pl), .in_pw(in_pw),
    .nn_sl(nn_sl), .nn_sw(nn_sw), .nn_pl(nn_pl), .nn_pw(nn_pw),
    .nn_species(nn_species), .nn_final(nn_final),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_species(out_species), .out_score(out_score),
    .cnt_c0(cnt_c0), .cnt_c1(cnt_c1), .cnt_c2(cnt_c2),
    .clr_counts(clr_counts), .busy(busy)
  );

  // ---- LATENCY=1 DUT ----
  logic        in_valid_b = 1'b0;
  logic        in_ready_b;
  logic [15:0] fb = '0;
  logic [15:0] nn_b;
  logic [3:0]  nn_species_b = '0;
  logic [31:0] nn_final_b   = '0;
  logic        out_valid_b;
  logic        out_ready_b  = 1'b0;
  logic [3:0]  out_species_b;
  logic [31:0] out_score_b;
  logic [15:0] cnt0_b, cnt1_b, cnt2_b;
  logic        busy_b;

  nn_sequencer #(.LATENCY(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_sl(fb[15:12]), .in_sw(fb[11:8]), .in_pl(fb[7:4]), .in_pw(fb[3:0]),
    .nn_sl(nn_b[15:12]), .nn_sw(nn_b[11:8]), .nn_pl(nn_b[7:4]), .nn_pw(nn_b[3:0]),
    .nn_species(nn_species_b), .nn_final(nn_final_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_species(out_species_b), .out_score(out_score_b),
    .cnt_c0(cnt0_b), .cnt_c1(cnt1_b), .cnt_c2(cnt2_b),
    .clr_counts(1'b0), .busy(busy_b)
  );

  // ---- scoreboard and reference model ----
  typedef struct {
    logic [3:0]  sp;
    logic [31:0] sc;
    logic [15:0] feat;
    int          acc;
    int          c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  int   m[3]    = '{0, 0, 0};
  bit   pending = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- monitor ----
  exp_t cur;
  bit   have = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have = 1'b0;
    end else if (out_valid) begin
      if (!have) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
          chk("capture_cycle", 64'(cyc), 64'(cur.acc + int'(LAT)));
          chk("cnt_c0", 64'(cnt_c0), 64'(cur.c0));
          chk("cnt_c1", 64'(cnt_c1), 64'(cur.c1));
          chk("cnt_c2", 64'(cnt_c2), 64'(cur.c2));
        end
      end
      if (have) begin
        chk("out_species", 64'(out_species), 64'(cur.sp));
        chk("out_score", 64'(out_score), 64'(cur.sc));
        chk("nn_held", 64'({nn_sl, nn_sw, nn_pl, nn_pw}), 64'(cur.feat));
        chk("busy_in_result", 64'(busy), 64'd1);
      end
      if (!out_ready) chk("in_ready_in_result", 64'(in_ready), 64'd0);
      else have = 1'b0;
    end else if (busy) begin
      chk("in_ready_in_settle", 64'(in_ready), 64'd0);
    end
  end

  // ---- driver tasks ----
  task automatic check_reset_vals(input string tag);
    chk({tag, "_nn"}, 64'({nn_sl, nn_sw, nn_pl, nn_pw}), 64'd0);
    chk({tag, "_out_species"}, 64'(out_species), 64'd0);
    chk({tag, "_out_score"}, 64'(out_score), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_cnt0"}, 64'(cnt_c0), 64'd0);
    chk({tag, "_cnt1"}, 64'(cnt_c1), 64'd0);
    chk({tag, "_cnt2"}, 64'(cnt_c2), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Offer sample f, keeping any pending result unconsumed for rd cycles first.
  // The datapath output is noise during the settle window except on the
  // capture cycle, where it shows (sp, sc).
  task automatic send(input logic [15:0] f, input logic [3:0] sp, input logic [31:0] sc,
                      input int rd, input bit clr_cap);
    exp_t e;
    int   budget;
    int   s;
    in_valid = 1'b1;
    {in_sl, in_sw, in_pl, in_pw} = f;
    if (pending) begin
      repeat (rd) tick();
      out_ready = 1'b1;
    end
    budget = 0;
    #1;
    while (!in_ready && budget < 60) begin
      tick();
      #1;
      budget++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      return;
    end
    tick();
    pending   = 1'b0;
    out_ready = 1'b0;
    chk("nn_after_accept", 64'({nn_sl, nn_sw, nn_pl, nn_pw}), 64'(f));
    s = int'(sp);
    if (clr_cap) m = '{0, 0, 0};
    else if (s < 3 && m[s] < CMAX) m[s] = m[s] + 1;
    e.sp = sp; e.sc = sc; e.feat = f; e.acc = cyc;
    e.c0 = m[0]; e.c1 = m[1]; e.c2 = m[2];
    sb.push_back(e);
    in_valid = 1'($urandom);
    {in_sl, in_sw, in_pl, in_pw} = 16'($urandom);
    for (int k = 1; k <= int'(LAT); k++) begin
      if (k == int'(LAT)) begin
        nn_species = sp;
        nn_final   = sc;
        clr_counts = clr_cap;
      end else begin
        nn_species = 4'($urandom);
        nn_final   = $urandom;
      end
      tick();
    end
    clr_counts = 1'b0;
    in_valid   = 1'b0;
    nn_species = 4'($urandom);
    nn_final   = $urandom;
    pending    = 1'b1;
  endtask

  task automatic release_idle();
    if (pending) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      pending   = 1'b0;
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic clear_idle();
    release_idle();
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    m = '{0, 0, 0};
    chk("clr_cnt0", 64'(cnt_c0), 64'd0);
    chk("clr_cnt1", 64'(cnt_c1), 64'd0);
    chk("clr_cnt2", 64'(cnt_c2), 64'd0);
  endtask

  task automatic reset_abort();
    release_idle();
    in_valid = 1'b1;
    {in_sl, in_sw, in_pl, in_pw} = 16'hA7C3;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    // The wait counter loads LATENCY-1 (23) on accept.
    // After 13 more edges it reads 10.
    repeat (13) begin
      nn_species = 4'($urandom);
      nn_final   = $urandom;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    m = '{0, 0, 0};
    pending = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    // A stray result after release would appear with the scoreboard empty.
    repeat (40) tick();
    chk("after_abort_busy", 64'(busy), 64'd0);
  endtask

  task automatic phase_b();
    in_valid_b   = 1'b1;
    out_ready_b  = 1'b1;
    nn_species_b = 4'd1;
    nn_final_b   = 32'h3F000000;
    fb           = 16'h1234;
    #1;
    chk("b_in_ready_idle", 64'(in_ready_b), 64'd1);
    tick();
    // Accepts land at E0, E2 and E4; results show after E1, E3 and E5.
    for (int k = 0; k <= 6; k++) begin
      if (k == 4) in_valid_b = 1'b0;
      #2;
      chk("b_out_valid", 64'(out_valid_b), 64'(k % 2 == 1));
      chk("b_busy", 64'(busy_b), 64'(k < 6));
      if (k % 2 == 1) begin
        chk("b_out_species", 64'(out_species_b), 64'd1);
        chk("b_out_score", 64'(out_score_b), 64'h3F000000);
      end
      tick();
    end
    chk("b_cnt_c1", 64'(cnt1_b), 64'd3);
    chk("b_cnt_c0", 64'(cnt0_b), 64'd0);
    chk("b_cnt_c2", 64'(cnt2_b), 64'd0);
    chk("b_nn", 64'(nn_b), 64'h1234);
  endtask

  // ---- main sequence ----
  initial begin
    logic [3:0] sp;
    #2 rst_n = 1'b0;
    #20;
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    send(16'h5310, 4'd0, 32'h3F7AE148, 0, 1'b0);
    send(16'hABCD, 4'd2, 32'h3F4CCCCD, 10, 1'b0);
    release_idle();

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) release_idle();
      sp = ($urandom_range(0, 7) < 6) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
      send(16'($urandom), sp, $urandom, int'($urandom_range(0, 4)),
           ($urandom_range(0, 7) == 0));
    end

    clear_idle();
    for (int i = 0; i < 17; i++) send(16'($urandom), 4'd1, $urandom, 0, 1'b0);
    send(16'($urandom), 4'd1, $urandom, 0, 1'b1);

    reset_abort();
    send(16'h2468, 4'd2, 32'h3F800000, 1, 1'b0);
    release_idle();

    phase_b();

    repeat (5) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
